// File: rtl/uart_rx_if.sv
// Line-control word-length encoding and the receive-side valid/ready output bundle.
package uart_pkg;
   typedef enum logic [1:0] {
      WL5 = 2'd0,
      WL6 = 2'd1,
      WL7 = 2'd2,
      WL8 = 2'd3
   } word_len_e;
endpackage

interface uart_rx_if;
   logic       rx_valid;
   logic       rx_ready;
   logic [7:0] rx_data;
   logic       rx_parity_err;
   logic       rx_frame_err;
   logic       rx_break;
   logic       rx_overrun;

   modport master (
      output rx_valid, rx_data, rx_parity_err, rx_frame_err, rx_break, rx_overrun,
      input  rx_ready
   );

   modport slave (
      input  rx_valid, rx_data, rx_parity_err, rx_frame_err, rx_break, rx_overrun,
      output rx_ready
   );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled start detect, mid-bit sampling, 5-8 data bits,
// optional parity, single checked stop bit, frame presented on a valid/ready bundle.
module uart_rx
   import uart_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx,
   input  logic       div_clk_en,
   uart_rx_if.master  rx_bus,
   input  word_len_e  cfg_word_len,
   input  logic       cfg_parity_en,
   input  logic       cfg_even_parity,
   input  logic       cfg_force_parity
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_e;

   state_e     r_state;
   logic       r_sync1, r_sync2, r_rx_d;
   logic [3:0] r_tick;
   logic [2:0] r_bit_cnt;
   logic [7:0] r_sh;
   logic       r_acc;
   logic       r_zero;
   logic       r_perr;

   logic       r_valid;
   logic [7:0] r_data;
   logic       r_perr_o;
   logic       r_ferr_o;
   logic       r_brk_o;
   logic       r_ovr;

   logic       w_fall;
   logic       w_sample;
   logic       w_last_bit;
   logic       w_exp_par;
   logic       w_done;
   logic [1:0] w_shift;
   logic [7:0] w_aligned;

   assign w_fall     = r_rx_d & ~r_sync2;
   assign w_sample   = div_clk_en & (r_tick == 4'd7);
   assign w_last_bit = (r_bit_cnt == ({1'b0, cfg_word_len} + 3'd4));
   assign w_exp_par  = cfg_force_parity ? ~cfg_even_parity : r_acc;
   assign w_done     = (r_state == S_STOP) & w_sample;
   // Bits enter at the MSB, so a short word sits in the top of r_sh.
   assign w_shift    = 2'd3 - cfg_word_len;
   assign w_aligned  = r_sh >> w_shift;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_sync1   <= 1'b1;
         r_sync2   <= 1'b1;
         r_rx_d    <= 1'b1;
         r_state   <= S_IDLE;
         r_tick    <= '0;
         r_bit_cnt <= '0;
         r_sh      <= '0;
         r_acc     <= 1'b0;
         r_zero    <= 1'b0;
         r_perr    <= 1'b0;
         r_valid   <= 1'b0;
         r_data    <= '0;
         r_perr_o  <= 1'b0;
         r_ferr_o  <= 1'b0;
         r_brk_o   <= 1'b0;
         r_ovr     <= 1'b0;
      end else begin
         r_sync1 <= rx;
         r_sync2 <= r_sync1;
         r_rx_d  <= r_sync2;

         if ((r_state != S_IDLE) && div_clk_en)
            r_tick <= r_tick + 4'd1;

         case (r_state)
            S_IDLE: begin
               if (w_fall) begin
                  r_state   <= S_START;
                  r_tick    <= '0;
                  r_bit_cnt <= '0;
                  r_acc     <= ~cfg_even_parity;
                  r_zero    <= 1'b1;
                  r_perr    <= 1'b0;
               end
            end
            S_START: begin
               if (w_sample)
                  r_state <= r_sync2 ? S_IDLE : S_DATA;
            end
            S_DATA: begin
               if (w_sample) begin
                  r_sh      <= {r_sync2, r_sh[7:1]};
                  r_acc     <= r_acc ^ r_sync2;
                  r_zero    <= r_zero & ~r_sync2;
                  r_bit_cnt <= r_bit_cnt + 3'd1;
                  if (w_last_bit)
                     r_state <= cfg_parity_en ? S_PARITY : S_STOP;
               end
            end
            S_PARITY: begin
               if (w_sample) begin
                  r_perr  <= (r_sync2 != w_exp_par);
                  r_zero  <= r_zero & ~r_sync2;
                  r_state <= S_STOP;
               end
            end
            S_STOP: begin
               if (w_sample)
                  r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase

         // A completed frame may replace the held one only in the cycle it is accepted.
         r_ovr <= 1'b0;
         if (w_done) begin
            if (!r_valid || rx_bus.rx_ready) begin
               r_valid  <= 1'b1;
               r_data   <= w_aligned;
               r_perr_o <= r_perr;
               r_ferr_o <= ~r_sync2;
               r_brk_o  <= r_zero & ~r_sync2;
            end else begin
               r_ovr <= 1'b1;
            end
         end else if (r_valid && rx_bus.rx_ready) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign rx_bus.rx_valid      = r_valid;
   assign rx_bus.rx_data       = r_data;
   assign rx_bus.rx_parity_err = r_perr_o;
   assign rx_bus.rx_frame_err  = r_ferr_o;
   assign rx_bus.rx_break      = r_brk_o;
   assign rx_bus.rx_overrun    = r_ovr;

endmodule
